// File: rtl/fetch_controller.sv
// Instruction fetch sequencer: walks the ROM and queues {instr, word addr}; fetch-to-head latency 1 cycle.
// Consumer backpressure fills the DEPTH-entry queue and then stalls the PC; a full queue still pushes on a pop.
module fetch_controller #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     reset,
    output logic [7:0]               rom_addr,
    input  logic [31:0]              rom_data,
    output logic                     out_valid,
    output logic [31:0]              out_instr,
    output logic [31:0]              out_pc,
    input  logic                     out_ready,
    input  logic                     redirect_valid,
    input  logic [31:0]              redirect_pc,
    output logic                     halted,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [7:0]    pc_q, pc_d;
    logic          halted_q, halted_d;
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;

    logic [31:0]   instr_mem [DEPTH];
    logic [7:0]    addr_mem  [DEPTH];

    logic          pop;
    logic          can_push;
    logic          push;
    logic          redirect_pc_unused;

    assign redirect_pc_unused = ^{redirect_pc[31:10], redirect_pc[1:0]};

    assign rom_addr  = pc_q;
    assign halted    = halted_q;
    assign count     = count_q;
    assign out_valid = (count_q != '0);
    assign out_instr = out_valid ? instr_mem[head_q] : 32'h0;
    assign out_pc    = out_valid ? {22'h0, addr_mem[head_q], 2'b00} : 32'h0;

    always_comb begin
        pop      = out_valid & out_ready;
        can_push = !halted_q && !redirect_valid && ((count_q < CW'(DEPTH)) || pop);
        push     = can_push && (rom_data != 32'h0);

        pc_d     = pc_q;
        halted_d = halted_q;
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;

        if (redirect_valid) begin
            pc_d     = redirect_pc[9:2];
            halted_d = 1'b0;
            head_d   = '0;
            tail_d   = '0;
            count_d  = '0;
        end else begin
            if (pop) begin
                head_d = head_q + PW'(1);
            end
            if (push) begin
                tail_d = tail_q + PW'(1);
            end
            // A zero word, or the last ROM word, stops fetch with the PC parked where it is.
            if (can_push) begin
                if ((rom_data == 32'h0) || (pc_q == 8'hFF)) begin
                    halted_d = 1'b1;
                end else begin
                    pc_d = pc_q + 8'd1;
                end
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q     <= 8'h0;
            halted_q <= 1'b0;
            head_q   <= '0;
            tail_q   <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            halted_q <= halted_d;
            head_q   <= head_d;
            tail_q   <= tail_d;
            count_q  <= count_d;
        end
    end

    // Queue payload needs no reset: the head is masked whenever count is zero.
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[tail_q] <= rom_data;
            addr_mem[tail_q]  <= pc_q;
        end
    end

endmodule
